// File: rtl/boolean_sweep_ctrl.sv
// boolean_sweep_ctrl: sweeps all eight {A,B,C} vectors into a Boolean block,
// samples F after a settle time and checks it against an expected truth table.
module boolean_sweep_ctrl #(
   parameter logic [7:0]  EXPECTED = 8'b1000_0000,
   parameter int unsigned SETTLE   = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       abort,
   input  logic       f_in,
   output logic       a_out,
   output logic       b_out,
   output logic       c_out,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [7:0] fail_mask,
   output logic [3:0] fail_count,
   output logic [2:0] first_fail_idx
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SETTLE,
      S_SAMPLE,
      S_DONE
   } state_t;

   localparam logic [3:0] WAIT_LAST = 4'(SETTLE - 1);

   state_t     state_q, state_d;
   logic [2:0] idx_q, idx_d;
   logic [3:0] wait_q, wait_d;
   logic [7:0] mask_q, mask_d;
   logic [3:0] cnt_q, cnt_d;
   logic [2:0] first_q, first_d;
   logic       pass_q, pass_d;
   logic       mism;
   logic       active;

   assign mism   = f_in ^ EXPECTED[idx_q];
   assign active = (state_q == S_SETTLE) || (state_q == S_SAMPLE);

   // State and result registers; reset clears everything at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         idx_q   <= 3'd0;
         wait_q  <= 4'd0;
         mask_q  <= 8'd0;
         cnt_q   <= 4'd0;
         first_q <= 3'd0;
         pass_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         wait_q  <= wait_d;
         mask_q  <= mask_d;
         cnt_q   <= cnt_d;
         first_q <= first_d;
         pass_q  <= pass_d;
      end
   end

   // Next-state logic: abort wins over a completing sample.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      wait_d  = wait_q;
      mask_d  = mask_q;
      cnt_d   = cnt_q;
      first_d = first_q;
      pass_d  = pass_q;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_SETTLE;
               idx_d   = 3'd0;
               wait_d  = 4'd0;
               mask_d  = 8'd0;
               cnt_d   = 4'd0;
               first_d = 3'd0;
               pass_d  = 1'b0;
            end
         end
         S_SETTLE: begin
            if (abort) begin
               state_d = S_IDLE;
            end else begin
               wait_d = wait_q + 4'd1;
               if (wait_q == WAIT_LAST) begin
                  state_d = S_SAMPLE;
               end
            end
         end
         S_SAMPLE: begin
            if (abort) begin
               state_d = S_IDLE;
            end else begin
               if (mism) begin
                  mask_d = mask_q | (8'd1 << idx_q);
                  cnt_d  = cnt_q + 4'd1;
                  if (cnt_q == 4'd0) begin
                     first_d = idx_q;
                  end
               end
               if (idx_q == 3'd7) begin
                  state_d = S_DONE;
                  pass_d  = (mask_d == 8'd0);
               end else begin
                  state_d = S_SETTLE;
                  idx_d   = idx_q + 3'd1;
                  wait_d  = 4'd0;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign busy           = active;
   assign done           = (state_q == S_DONE);
   assign {a_out, b_out, c_out} = active ? idx_q : 3'd0;
   assign pass           = pass_q;
   assign fail_mask      = mask_q;
   assign fail_count     = cnt_q;
   assign first_fail_idx = first_q;

endmodule

// File: tb/tb_boolean_sweep_ctrl.sv
// tb_boolean_sweep_ctrl: scoreboard bench for boolean_sweep_ctrl,
// default instance (SETTLE=2) and a SETTLE=4 instance.
module tb_boolean_sweep_ctrl;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int mode_a = 0;
   int mode_b = 0;

   logic start_a = 1'b0, abort_a = 1'b0, f_a;
   logic start_b = 1'b0, abort_b = 1'b0, f_b;
   logic a_a, b_a, c_a, busy_a, done_a, pass_a;
   logic a_b, b_b, c_b, busy_b, done_b, pass_b;
   logic [7:0] mask_a, mask_b;
   logic [3:0] cnt_a, cnt_b;
   logic [2:0] ff_a, ff_b;

   typedef struct packed {
      logic       pass;
      logic [7:0] mask;
      logic [3:0] cnt;
      logic [2:0] first;
   } res_t;

   res_t sb[$];

   // Behavioural models of the block under test: 0 AND3, 1 OR3,
   // 2 AND3 wrong at index 5, 3 AND3 wrong at index 1.
   function automatic logic model(int mode, logic [2:0] v);
      logic and3;
      and3 = &v;
      case (mode)
         1: return |v;
         2: return and3 ^ (v == 3'd5);
         3: return and3 ^ (v == 3'd1);
         default: return and3;
      endcase
   endfunction

   function automatic res_t predict(int mode, int nvec, logic [7:0] tt);
      res_t r;
      bit seen;
      r = '0;
      seen = 0;
      for (int i = 0; i < nvec; i++) begin
         if (model(mode, 3'(i)) != tt[i]) begin
            r.mask[i] = 1'b1;
            r.cnt = r.cnt + 4'd1;
            if (!seen) begin
               r.first = 3'(i);
               seen = 1;
            end
         end
      end
      r.pass = (nvec == 8) && (r.mask == 8'd0);
      return r;
   endfunction

   assign f_a = model(mode_a, {a_a, b_a, c_a});
   assign f_b = model(mode_b, {a_b, b_b, c_b});

   boolean_sweep_ctrl u_dut_a (
      .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a),
      .f_in(f_a), .a_out(a_a), .b_out(b_a), .c_out(c_a),
      .busy(busy_a), .done(done_a), .pass(pass_a),
      .fail_mask(mask_a), .fail_count(cnt_a), .first_fail_idx(ff_a)
   );

   boolean_sweep_ctrl #(.EXPECTED(8'b1000_0000), .SETTLE(4)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b),
      .f_in(f_b), .a_out(a_b), .b_out(b_b), .c_out(c_b),
      .busy(busy_b), .done(done_b), .pass(pass_b),
      .fail_mask(mask_b), .fail_count(cnt_b), .first_fail_idx(ff_b)
   );

   // Start is sampled on the returned posedge (edge 0).
   task automatic pulse_start_a();
      @(negedge clk);
      start_a = 1'b1;
      @(posedge clk);
      #1 start_a = 1'b0;
   endtask

   task automatic pulse_start_b();
      @(negedge clk);
      start_b = 1'b1;
      @(posedge clk);
      #1 start_b = 1'b0;
   endtask

   // cyc = n where done is seen in the cycle after edge n; -1 on timeout.
   task automatic wait_done_a(input int budget, output int cyc);
      cyc = -1;
      for (int n = 0; n < budget; n++) begin
         @(negedge clk);
         if (done_a === 1'b1) begin
            cyc = n;
            break;
         end
      end
   endtask

   task automatic wait_done_b(input int budget, output int cyc);
      cyc = -1;
      for (int n = 0; n < budget; n++) begin
         @(negedge clk);
         if (done_b === 1'b1) begin
            cyc = n;
            break;
         end
      end
   endtask

   task automatic test_reset();
      logic [17:0] obs;
      #2;
      obs = {a_a, b_a, c_a, busy_a, done_a, pass_a, mask_a, cnt_a, ff_a};
      checks++;
      if (obs !== 18'd0) begin
         failures++;
         $display("FAIL reset_a got=%h want=0", obs);
      end
      obs = {a_b, b_b, c_b, busy_b, done_b, pass_b, mask_b, cnt_b, ff_b};
      checks++;
      if (obs !== 18'd0) begin
         failures++;
         $display("FAIL reset_b got=%h want=0", obs);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_and3();
      res_t r, obs;
      mode_a = 0;
      sb.push_back(predict(0, 8, 8'h80));
      pulse_start_a();
      for (int n = 0; n < 30; n++) begin
         @(negedge clk);
         if (n < 24) begin
            checks++;
            if ({a_a, b_a, c_a} !== 3'(n / 3)) begin
               failures++;
               $display("FAIL and3_vec n=%0d got=%0d want=%0d",
                        n, {a_a, b_a, c_a}, n / 3);
            end
         end
         checks++;
         if (busy_a !== (n < 24)) begin
            failures++;
            $display("FAIL and3_busy n=%0d got=%b", n, busy_a);
         end
         checks++;
         if (done_a !== (n == 24)) begin
            failures++;
            $display("FAIL and3_done n=%0d got=%b", n, done_a);
         end
         if (n == 24) begin
            r = sb.pop_front();
            obs = {pass_a, mask_a, cnt_a, ff_a};
            checks++;
            if (obs !== r) begin
               failures++;
               $display("FAIL and3_res got=%h want=%h", obs, r);
            end
         end
      end
   endtask

   task automatic test_or3();
      res_t r, obs;
      int cyc;
      mode_a = 1;
      sb.push_back(predict(1, 8, 8'h80));
      pulse_start_a();
      wait_done_a(40, cyc);
      checks++;
      if (cyc != 24) begin
         failures++;
         $display("FAIL or3_done_cyc got=%0d want=24", cyc);
      end
      r = sb.pop_front();
      obs = {pass_a, mask_a, cnt_a, ff_a};
      checks++;
      if (obs !== r) begin
         failures++;
         $display("FAIL or3_res got=%h want=%h", obs, r);
      end
      checks++;
      if (mask_a !== 8'b0111_1110 || cnt_a !== 4'd6) begin
         failures++;
         $display("FAIL or3_mask got=%b/%0d want=01111110/6",
                  mask_a, cnt_a);
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic test_idx5_settle4();
      res_t r, obs;
      int cyc;
      mode_b = 2;
      sb.push_back(predict(2, 8, 8'h80));
      pulse_start_b();
      wait_done_b(60, cyc);
      checks++;
      if (cyc != 40) begin
         failures++;
         $display("FAIL idx5_done_cyc got=%0d want=40", cyc);
      end
      r = sb.pop_front();
      obs = {pass_b, mask_b, cnt_b, ff_b};
      checks++;
      if (obs !== r) begin
         failures++;
         $display("FAIL idx5_res got=%h want=%h", obs, r);
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic test_abort();
      res_t r, obs;
      bit saw_done;
      mode_a = 3;
      saw_done = 0;
      sb.push_back(predict(3, 3, 8'h80));
      pulse_start_a();
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         if (done_a === 1'b1) saw_done = 1;
         if (n == 7) start_a = 1'b1;
         if (n == 8) begin
            checks++;
            if ({a_a, b_a, c_a} !== 3'd2 || busy_a !== 1'b1) begin
               failures++;
               $display("FAIL abort_restart got=%0d busy=%b want=2",
                        {a_a, b_a, c_a}, busy_a);
            end
            start_a = 1'b0;
         end
         if (n == 9) begin
            checks++;
            if ({a_a, b_a, c_a} !== 3'd3) begin
               failures++;
               $display("FAIL abort_vec9 got=%0d want=3",
                        {a_a, b_a, c_a});
            end
            abort_a = 1'b1;
         end
         if (n == 10) begin
            abort_a = 1'b0;
            checks++;
            if (busy_a !== 1'b0 || {a_a, b_a, c_a} !== 3'd0) begin
               failures++;
               $display("FAIL abort_busy got=%b want=0", busy_a);
            end
            r = sb.pop_front();
            obs = {pass_a, mask_a, cnt_a, ff_a};
            checks++;
            if (obs !== r) begin
               failures++;
               $display("FAIL abort_res got=%h want=%h", obs, r);
            end
         end
      end
      checks++;
      if (saw_done) begin
         failures++;
         $display("FAIL abort_no_done got=1 want=0");
      end
   endtask

   task automatic test_back_to_back();
      res_t r, obs;
      int dc[$];
      mode_a = 0;
      for (int k = 0; k < 3; k++) sb.push_back(predict(0, 8, 8'h80));
      @(negedge clk);
      start_a = 1'b1;
      @(posedge clk);
      for (int n = 0; n < 100; n++) begin
         @(negedge clk);
         if (n == 0) begin
            checks++;
            if (mask_a !== 8'd0 || cnt_a !== 4'd0 || ff_a !== 3'd0) begin
               failures++;
               $display("FAIL b2b_clear got=%b/%0d/%0d want=0",
                        mask_a, cnt_a, ff_a);
            end
         end
         if (n == 76) start_a = 1'b0;
         if (done_a === 1'b1) begin
            dc.push_back(n);
            checks++;
            if (sb.size() == 0) begin
               failures++;
               $display("FAIL b2b_extra_done n=%0d", n);
            end else begin
               r = sb.pop_front();
               obs = {pass_a, mask_a, cnt_a, ff_a};
               if (obs !== r) begin
                  failures++;
                  $display("FAIL b2b_res n=%0d got=%h want=%h", n, obs, r);
               end
            end
         end
      end
      checks++;
      if (dc.size() != 3) begin
         failures++;
         $display("FAIL b2b_count got=%0d want=3", dc.size());
      end else begin
         for (int k = 0; k < 3; k++) begin
            checks++;
            if (dc[k] != 24 + 26 * k) begin
               failures++;
               $display("FAIL b2b_cyc k=%0d got=%0d want=%0d",
                        k, dc[k], 24 + 26 * k);
            end
         end
      end
      sb.delete();
   endtask

   task automatic test_reset_mid();
      res_t r, obs;
      logic [17:0] all;
      int cyc;
      mode_a = 1;
      pulse_start_a();
      repeat (14) @(negedge clk);
      checks++;
      if (busy_a !== 1'b1 || mask_a === 8'd0) begin
         failures++;
         $display("FAIL rstmid_pre busy=%b mask=%b want busy=1 mask!=0",
                  busy_a, mask_a);
      end
      #1 rst_n = 1'b0;
      #1;
      all = {a_a, b_a, c_a, busy_a, done_a, pass_a, mask_a, cnt_a, ff_a};
      checks++;
      if (all !== 18'd0) begin
         failures++;
         $display("FAIL rstmid_async got=%h want=0", all);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      mode_a = 0;
      sb.push_back(predict(0, 8, 8'h80));
      pulse_start_a();
      wait_done_a(40, cyc);
      checks++;
      if (cyc != 24) begin
         failures++;
         $display("FAIL rstmid_done_cyc got=%0d want=24", cyc);
      end
      r = sb.pop_front();
      obs = {pass_a, mask_a, cnt_a, ff_a};
      checks++;
      if (obs !== r || pass_a !== 1'b1) begin
         failures++;
         $display("FAIL rstmid_res got=%h want=%h", obs, r);
      end
   endtask

   initial begin
      test_reset();
      test_and3();
      test_or3();
      test_idx5_settle4();
      test_abort();
      test_back_to_back();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
